// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: four-digit seven-segment scan with per-slot dead time and whole-display flash
module seg_scan_scheduler #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int FLASH_SLOTS  = 250
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [27:0] DigitSegs,
    input  logic [3:0]  DigitMask,
    input  logic        FlashEn,
    output logic [3:0]  DigitEn,
    output logic [6:0]  Seg,
    output logic        FlashPhase,
    output logic        SlotTick
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(FLASH_SLOTS + 1);
    localparam logic [DW-1:0] BLK_LAST = DW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_SLOTS - 1);
    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
    state_t            state, state_n;
    logic [DW-1:0]     div, div_n;
    logic [1:0]        slot, slot_n;
    logic [FW-1:0]     fcnt, fcnt_n;
    logic [3:0][6:0]   frame, frame_n;
    logic [3:0]        en_n;
    logic [6:0]        seg_n;
    logic              phase_n, tick_n, boundary;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= OFF;
            div        <= '0;
            slot       <= '0;
            fcnt       <= '0;
            frame      <= '0;
            DigitEn    <= '0;
            Seg        <= '0;
            SlotTick   <= 1'b0;
            FlashPhase <= 1'b1;
        end else begin
            state      <= state_n;
            div        <= div_n;
            slot       <= slot_n;
            fcnt       <= fcnt_n;
            frame      <= frame_n;
            DigitEn    <= en_n;
            Seg        <= seg_n;
            SlotTick   <= tick_n;
            FlashPhase <= phase_n;
        end
    end
    always_comb begin
        state_n  = state;
        div_n    = div;
        slot_n   = slot;
        fcnt_n   = fcnt;
        frame_n  = frame;
        phase_n  = FlashPhase;
        tick_n   = 1'b0;
        boundary = (state == SHOW) && (div == DIV_LAST);
        if (!Enable) begin
            state_n = OFF;
            div_n   = '0;
            slot_n  = '0;
            fcnt_n  = '0;
            phase_n = 1'b1;
        end else begin
            case (state)
                OFF: begin
                    state_n = BLANK;
                    frame_n = DigitSegs;
                end
                BLANK: begin
                    div_n   = div + 1'b1;
                    state_n = (div == BLK_LAST) ? SHOW : BLANK;
                end
                SHOW: begin
                    div_n   = boundary ? '0 : div + 1'b1;
                    state_n = boundary ? BLANK : SHOW;
                    slot_n  = boundary ? slot + 2'd1 : slot;
                    tick_n  = boundary;
                    // frame reloads only at frame start so a frame never tears
                    frame_n = (boundary && slot == 2'd3) ? DigitSegs : frame;
                end
                default: state_n = OFF;
            endcase
            if (!FlashEn) begin
                fcnt_n  = '0;
                phase_n = 1'b1;
            end else if (boundary) begin
                fcnt_n  = (fcnt == FL_LAST) ? '0 : fcnt + 1'b1;
                phase_n = (fcnt == FL_LAST) ? !FlashPhase : FlashPhase;
            end
        end
        // outputs are registered from the upcoming state so a slot change always starts dark
        seg_n = (state_n == OFF) ? 7'd0 : frame_n[slot_n];
        en_n  = (state_n == SHOW) ? ((4'b0001 << slot_n) & DigitMask & {4{!FlashEn | FlashPhase}}) : 4'd0;
    end
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler: randomized scoreboard bench against a slot-arithmetic reference model
module tb_seg_scan_scheduler;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FS = 4;
    logic        Clk = 1'b0;
    logic        Reset, Enable, FlashEn;
    logic [27:0] DigitSegs;
    logic [3:0]  DigitMask;
    logic [3:0]  DigitEn;
    logic [6:0]  Seg;
    logic        FlashPhase, SlotTick;
    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
        logic       ph;
        logic       tick;
    } exp_t;
    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    bit on = 0;
    int t = 0;
    int bsf = 0;
    bit phase = 1;
    logic [3:0][6:0] frame = '0;

    seg_scan_scheduler #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .FLASH_SLOTS(FS)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .DigitSegs(DigitSegs),
        .DigitMask(DigitMask), .FlashEn(FlashEn), .DigitEn(DigitEn), .Seg(Seg),
        .FlashPhase(FlashPhase), .SlotTick(SlotTick)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // model: position in the scan is plain elapsed time since enable; flash phase from boundary count
    task automatic model();
        exp_t e;
        int slot, pos;
        bit bnd;
        bnd = 0;
        if (Reset || !Enable) begin
            on = 0; t = 0; bsf = 0; phase = 1;
            if (Reset) frame = '0;
        end else begin
            if (!on) begin
                on = 1; t = 0; frame = DigitSegs;
            end else begin
                t++;
                if (t % SD == 0) begin
                    bnd = 1;
                    if ((t / SD) % 4 == 0) frame = DigitSegs;
                end
            end
            if (!FlashEn) begin
                bsf = 0; phase = 1;
            end else if (bnd) begin
                bsf++;
                phase = ((bsf / FS) % 2) == 0;
            end
        end
        slot = (t / SD) % 4;
        pos = t % SD;
        e.en = (on && pos >= BC) ? ((4'b0001 << slot) & DigitMask & {4{!FlashEn | phase}}) : 4'd0;
        e.seg = on ? frame[slot] : 7'd0;
        e.ph = phase;
        e.tick = on && bnd;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge Clk);
            model();
            @(negedge Clk);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("DigitEn", int'(DigitEn), int'(e.en));
                chk("Seg", int'(Seg), int'(e.seg));
                chk("FlashPhase", int'(FlashPhase), int'(e.ph));
                chk("SlotTick", int'(SlotTick), int'(e.tick));
                chk("onehot", int'($countones(DigitEn) <= 1), 1);
            end
        end
    end

    initial begin
        Reset = 1; Enable = 1; FlashEn = 0; DigitMask = 4'b1111;
        DigitSegs = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        run(3);
        Reset = 0;
        run(40);
        DigitMask = 4'b0101;
        run(32);
        DigitMask = 4'b1111;
        run(17);
        DigitSegs[6:0] = 7'h7F;
        run(40);
        FlashEn = 1;
        run(75);
        FlashEn = 0;
        run(10);
        run(7);
        Enable = 0;
        run(3);
        Enable = 1;
        run(20);
        for (int i = 0; i < 900; i++) begin
            Reset = ($urandom_range(299) == 0);
            Enable = ($urandom_range(119) != 0);
            if ($urandom_range(19) == 0) DigitMask = 4'($urandom);
            if ($urandom_range(29) == 0) DigitSegs = 28'($urandom);
            if ($urandom_range(149) == 0) FlashEn = !FlashEn;
            run(1);
        end
        Reset = 0; Enable = 1;
        run(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
